// File: rtl/hpdcache_sram_pkg.sv
// Shared types and byte-enable helpers for the HPDcache SRAM wrappers.
package hpdcache_sram_pkg;

  // The helpers are width-agnostic by working at a fixed maximum width; callers truncate.
  localparam int unsigned MAX_DATA_SIZE = 1024;
  localparam int unsigned MAX_BE_SIZE   = MAX_DATA_SIZE / 8;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    RMW_MERGE = 1'b1
  } hpdcache_sram_state_e;

  function automatic logic [MAX_DATA_SIZE-1:0] be_to_mask(input logic [MAX_BE_SIZE-1:0] be);
    logic [MAX_DATA_SIZE-1:0] mask;
    for (int unsigned i = 0; i < MAX_BE_SIZE; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  function automatic logic [MAX_DATA_SIZE-1:0] byte_merge(
    input logic [MAX_DATA_SIZE-1:0] old_data,
    input logic [MAX_DATA_SIZE-1:0] new_data,
    input logic [MAX_BE_SIZE-1:0]   be
  );
    logic [MAX_DATA_SIZE-1:0] mask;
    mask = be_to_mask(be);
    return (new_data & mask) | (old_data & ~mask);
  endfunction

endpackage

// File: rtl/hpdcache_sram_bytemerge.sv
// Combinational byte merge: enabled bytes from new_data, the rest from old_data.
module hpdcache_sram_bytemerge
  import hpdcache_sram_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic [DATA_SIZE-1:0]   old_data,
  input  logic [DATA_SIZE-1:0]   new_data,
  input  logic [DATA_SIZE/8-1:0] byteenable,
  output logic [DATA_SIZE-1:0]   merged
);

  logic [MAX_DATA_SIZE-1:0] merged_full;
  logic                     unused_merged;

  assign merged_full   = byte_merge(MAX_DATA_SIZE'(old_data), MAX_DATA_SIZE'(new_data),
                                    MAX_BE_SIZE'(byteenable));
  assign merged        = merged_full[DATA_SIZE-1:0];
  assign unused_merged = ^merged_full;

endmodule

// File: rtl/la_spram.sv
// Behavioural single-port RAM macro with bit write mask and registered read port.
module la_spram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [DW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce && we) begin
      mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
    end
    if (ce && !we) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/hpdcache_sram_wbyteenable_rmw.sv
// Byte-enable 1RW SRAM wrapper with native-mask or read-modify-write partial writes,
// a valid/ready request handshake and an optional output register.
module hpdcache_sram_wbyteenable_rmw
  import hpdcache_sram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 6,
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned DEPTH        = 2**ADDR_SIZE,
  parameter bit          WMASK_NATIVE = 1'b0,
  parameter bit          OUT_REG      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [DATA_SIZE-1:0]   req_wdata,
  input  logic [DATA_SIZE/8-1:0] req_wbyteenable,
  output logic                   rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_rdata
);

  localparam int unsigned BE_SIZE = DATA_SIZE / 8;

  if ((DATA_SIZE % 8) != 0 || DATA_SIZE >= MAX_DATA_SIZE || DEPTH > 2**ADDR_SIZE) begin : gen_bad_cfg
    $error("hpdcache_sram_wbyteenable_rmw: unsupported DATA_SIZE/DEPTH");
  end

  hpdcache_sram_state_e   state_q, state_d;
  logic [ADDR_SIZE-1:0]   rmw_addr_q;
  logic [DATA_SIZE-1:0]   rmw_wdata_q;
  logic [BE_SIZE-1:0]     rmw_be_q;
  logic                   rd_pending_q;
  logic [DATA_SIZE-1:0]   rdata_q;

  logic                   req_accept;
  logic                   be_full, be_null;
  logic                   rmw_start;
  logic [MAX_DATA_SIZE-1:0] req_mask_full;
  logic                   unused_mask;
  logic [DATA_SIZE-1:0]   merged;

  logic                   ram_ce, ram_we;
  logic [DATA_SIZE-1:0]   ram_wmask, ram_din, ram_dout;
  logic [ADDR_SIZE-1:0]   ram_addr;

  // Gating with rst_n keeps ready low for the whole reset, not just until the next edge.
  assign req_ready     = rst_n && (state_q == IDLE);
  assign req_accept    = req_valid && req_ready;
  assign be_full       = &req_wbyteenable;
  assign be_null       = ~|req_wbyteenable;
  assign rmw_start     = req_accept && req_we && !be_full && !be_null && !WMASK_NATIVE;
  assign req_mask_full = be_to_mask(MAX_BE_SIZE'(req_wbyteenable));
  assign unused_mask   = ^req_mask_full;

  hpdcache_sram_bytemerge #(
    .DATA_SIZE (DATA_SIZE)
  ) u_bytemerge (
    .old_data   (ram_dout),
    .new_data   (rmw_wdata_q),
    .byteenable (rmw_be_q),
    .merged     (merged)
  );

  always_comb begin
    state_d   = state_q;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr;
    ram_din   = req_wdata;
    ram_wmask = '1;
    unique case (state_q)
      IDLE: begin
        if (req_accept) begin
          if (!req_we) begin
            ram_ce = 1'b1;
          end else if (!be_null) begin
            ram_ce = 1'b1;
            if (rmw_start) begin
              // Read the old word now; the merged word is written next cycle.
              state_d = RMW_MERGE;
            end else begin
              ram_we = 1'b1;
              if (WMASK_NATIVE) begin
                ram_wmask = req_mask_full[DATA_SIZE-1:0];
              end
            end
          end
        end
      end
      RMW_MERGE: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = rmw_addr_q;
        ram_din  = merged;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rmw_addr_q   <= '0;
      rmw_wdata_q  <= '0;
      rmw_be_q     <= '0;
      rd_pending_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= req_accept && !req_we;
      if (rmw_start) begin
        rmw_addr_q  <= req_addr;
        rmw_wdata_q <= req_wdata;
        rmw_be_q    <= req_wbyteenable;
      end
      if (rd_pending_q) begin
        rdata_q <= ram_dout;
      end
    end
  end

  // rdata_q doubles as the hold register (OUT_REG=0) and the output stage (OUT_REG=1).
  if (OUT_REG) begin : gen_out_reg
    logic rsp_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_q <= 1'b0;
      end else begin
        rsp_valid_q <= rd_pending_q;
      end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
  end else begin : gen_no_out_reg
    assign rsp_valid = rd_pending_q;
    assign rsp_rdata = rd_pending_q ? ram_dout : rdata_q;
  end

  la_spram #(
    .DW    (DATA_SIZE),
    .AW    (ADDR_SIZE),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .ce    (ram_ce),
    .we    (ram_we),
    .wmask (ram_wmask),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

endmodule

// File: tb/tb_hpdcache_sram_wbyteenable_rmw.sv
// Directed bench for two configurations: (RMW, no out reg) and (native mask, out reg).
module tb_hpdcache_sram_wbyteenable_rmw;
  import hpdcache_sram_pkg::*;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [5:0]  req_addr [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_be [2];
  logic        rsp_valid [2];
  logic [63:0] rsp_rdata [2];

  logic [63:0] model [2][64];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc;
  int          checks;
  int          errors;

  hpdcache_sram_wbyteenable_rmw #(
    .ADDR_SIZE    (6),
    .DATA_SIZE    (64),
    .WMASK_NATIVE (1'b0),
    .OUT_REG      (1'b0)
  ) u_dut0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid[0]),
    .req_ready       (req_ready[0]),
    .req_we          (req_we[0]),
    .req_addr        (req_addr[0]),
    .req_wdata       (req_wdata[0]),
    .req_wbyteenable (req_be[0]),
    .rsp_valid       (rsp_valid[0]),
    .rsp_rdata       (rsp_rdata[0])
  );

  hpdcache_sram_wbyteenable_rmw #(
    .ADDR_SIZE    (6),
    .DATA_SIZE    (64),
    .WMASK_NATIVE (1'b1),
    .OUT_REG      (1'b1)
  ) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid[1]),
    .req_ready       (req_ready[1]),
    .req_we          (req_we[1]),
    .req_addr        (req_addr[1]),
    .req_wdata       (req_wdata[1]),
    .req_wbyteenable (req_be[1]),
    .rsp_valid       (rsp_valid[1]),
    .rsp_rdata       (rsp_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rsp_valid must match the oldest queued read, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && rsp_valid[i]) begin
        if (i == 0) have = (q0.size() > 0);
        else        have = (q1.size() > 0);
        checks++;
        assert (have === 1'b1) else begin
          errors++;
          $error("FAIL rsp_unexpected inst%0d: observed rsp_valid=1 expected 0", i);
        end
        if (have) begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          checks++;
          assert (rsp_rdata[i] === e.data) else begin
            errors++;
            $error("FAIL rsp_data inst%0d: observed %h expected %h", i, rsp_rdata[i], e.data);
          end
          checks++;
          assert (cyc === e.cyc) else begin
            errors++;
            $error("FAIL rsp_latency inst%0d: observed cycle %0d expected %0d", i, cyc, e.cyc);
          end
        end
      end
    end
  end

  function automatic logic [63:0] expand(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Issue one request; returns at the accepting edge with valid still high.
  task automatic do_req(input int i, input bit we, input logic [5:0] a, input logic [63:0] d,
                        input logic [7:0] be, input bit commit, output int stalls,
                        output bit ce_seen);
    exp_t e;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_be[i]    = be;
    stalls       = 0;
    #1;
    while (!req_ready[i] && stalls < 8) begin
      @(negedge clk);
      stalls++;
      #1;
    end
    checks++;
    assert (req_ready[i] === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout inst%0d: observed ready=%b expected 1", i, req_ready[i]);
    end
    if (i == 0) ce_seen = u_dut0.ram_ce;
    else        ce_seen = u_dut1.ram_ce;
    if (!we) begin
      e.data = model[i][a];
      e.cyc  = cyc + 1 + i;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end else if (commit) begin
      model[i][a] = (model[i][a] & ~expand(be)) | (d & expand(be));
    end
    @(posedge clk);
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int st;
    bit ce;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_int("reset_ready", int'(req_ready[i]), 0);
      chk_int("reset_rsp_valid", int'(rsp_valid[i]), 0);
      checks++;
      assert (rsp_rdata[i] === 64'h0) else begin
        errors++;
        $error("FAIL reset_rdata inst%0d: observed %h expected 0", i, rsp_rdata[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_int("ready_after_reset", int'(req_ready[i]), 1);

    // Preload through full writes.
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b1, 6'd5, 64'h1122334455667788, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b1, 6'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b1, 6'd7, 64'h0, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b1, 6'd9, 64'h0123456789ABCDEF, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b1, 6'd2, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b1, 6'd4, 64'h0011223344556677, 8'hFF, 1'b1, st, ce);
      idle(i);
    end

    // Reads, including back-to-back.
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b0, 6'd5, 64'h0, 8'h00, 1'b1, st, ce);
      do_req(i, 1'b0, 6'd2, 64'h0, 8'h00, 1'b1, st, ce);
      chk_int("b2b_read_stall", st, 0);
      do_req(i, 1'b0, 6'd9, 64'h0, 8'h00, 1'b1, st, ce);
      chk_int("b2b_read_stall", st, 0);
      idle(i);
    end

    // RMW partial write: exactly one stall cycle, then merged readback.
    do_req(0, 1'b1, 6'd3, 64'h0, 8'h0F, 1'b1, st, ce);
    do_req(0, 1'b0, 6'd3, 64'h0, 8'h00, 1'b1, st, ce);
    chk_int("rmw_stall", st, 1);
    idle(0);

    // Full write then immediate read, and null write.
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b1, 6'd7, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b1, st, ce);
      do_req(i, 1'b0, 6'd7, 64'h0, 8'h00, 1'b1, st, ce);
      chk_int("full_write_stall", st, 0);
      do_req(i, 1'b1, 6'd2, 64'h5555555555555555, 8'h00, 1'b1, st, ce);
      chk_int("null_write_ce", int'(ce), 0);
      do_req(i, 1'b0, 6'd2, 64'h0, 8'h00, 1'b1, st, ce);
      chk_int("null_write_stall", st, 0);
      idle(i);
    end

    // Partial write 0x81 in both modes.
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b1, 6'd4, 64'hFFEEDDCCBBAA9988, 8'h81, 1'b1, st, ce);
      do_req(i, 1'b0, 6'd4, 64'h0, 8'h00, 1'b1, st, ce);
      chk_int("partial_81_stall", st, (i == 0) ? 1 : 0);
      idle(i);
    end
    repeat (4) @(negedge clk);

    // Reset during RMW_MERGE; inst1 has a read in flight that must be dropped.
    fork
      do_req(0, 1'b1, 6'd9, 64'h0, 8'h0F, 1'b0, st, ce);
      begin
        int st1;
        bit ce1;
        do_req(1, 1'b0, 6'd9, 64'h0, 8'h00, 1'b1, st1, ce1);
      end
    join
    #2;
    chk_int("rmw_state_before_reset", int'(u_dut0.state_q), int'(RMW_MERGE));
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_int("mid_reset_state", int'(u_dut0.state_q), int'(IDLE));
    for (int i = 0; i < 2; i++) begin
      chk_int("mid_reset_rsp_valid", int'(rsp_valid[i]), 0);
      checks++;
      assert (rsp_rdata[i] === 64'h0) else begin
        errors++;
        $error("FAIL mid_reset_rdata inst%0d: observed %h expected 0", i, rsp_rdata[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("post_reset_ready", int'(req_ready[0]), 1);
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b0, 6'd9, 64'h0, 8'h00, 1'b1, st, ce);
      idle(i);
    end
    repeat (4) @(negedge clk);
    chk_int("missing_rsp_inst0", q0.size(), 0);
    chk_int("missing_rsp_inst1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
